// File: rtl/sift_pkg.sv
// sift_pkg: shared histogram constants, init/scan state encoding and a saturating add.
package sift_pkg;
  localparam int NBIN = 16;
  localparam int BW = 4;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN} st_e;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] s, m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return s > m ? m[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/hist_bank_ram.sv
// hist_bank_ram: simple dual-port synchronous RAM; a same-edge read returns the old contents.
module hist_bank_ram #(
  parameter int DEPTH = 64,
  parameter int AW = 6,
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/orient_hist_cell.sv
// orient_hist_cell: per-tile 16-bin magnitude-weighted orientation histograms in ping-pong
// banks; each closed tile row is scanned (and cleared) to report dominant bin and peak.
module orient_hist_cell import sift_pkg::*; #(
  parameter int WIDE = 256,
  parameter int HIGN = 256,
  parameter int DW = 8,
  parameter int CELL = 16,
  parameter int ACC_W = 16,
  parameter int CNT_DW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [DW-1:0]    mag_in,
  input  logic [BW-1:0]    the_in,
  output logic             hist_valid,
  output logic [7:0]       hist_cell_x,
  output logic [7:0]       hist_cell_y,
  output logic [BW-1:0]    hist_bin,
  output logic [ACC_W-1:0] hist_peak,
  output logic             frame_done,
  output logic             init_busy,
  output logic [1:0]       err
);
  localparam int NC = WIDE / CELL;
  localparam int AW = $clog2(NC * NBIN);
  localparam int CXW = AW - BW;
  localparam int LC = $clog2(CELL);
  st_e st_q;
  logic [AW:0] init_cnt_q, s0_a_q, s1_a_q, s2_a_q, pw_a_q;
  logic [CNT_DW-1:0] cnt_w_q, cnt_h_q;
  logic s0_v_q, s1_v_q, s2_v_q, pw_v_q, s0_last_q, s1_last_q, s2_last_q, s0_lf_q, s1_lf_q, s2_lf_q;
  logic [DW-1:0] s0_m_q, s1_m_q;
  logic [7:0] s0_cy_q, s1_cy_q, s2_cy_q, scan_cy_q, hx_q, hy_q;
  logic [ACC_W-1:0] s2_sum_q, pw_sum_q, fwd, sum_d, rdat, max_q, max_d, hp_q;
  logic [AW-1:0] scan_idx_q, r_idx_q;
  logic scan_bank_q, scan_lf_q, r_v_q, acc, row_end, last_bin, take, hv_q, fd_q;
  logic [BW-1:0] mbin_q, mbin_d, hb_q;
  logic [1:0] err_q;
  logic we [2];
  logic [AW-1:0] wa [2], ra [2];
  logic [ACC_W-1:0] wd [2], rd [2];
  assign acc = valid_in && st_q != ST_INIT;
  assign row_end = cnt_w_q == CNT_DW'(WIDE - 1) && &cnt_h_q[LC-1:0];
  // Newest in-flight write wins over the RAM's stale read data.
  assign fwd = s2_v_q && s2_a_q == s1_a_q ? s2_sum_q
             : pw_v_q && pw_a_q == s1_a_q ? pw_sum_q : rd[s1_a_q[AW]];
  assign sum_d = ACC_W'(sat_add(32'(fwd), 32'(s1_m_q), ACC_W));
  assign rdat = rd[scan_bank_q];
  assign last_bin = &r_idx_q[BW-1:0];
  assign take = r_idx_q[BW-1:0] == '0 || rdat > max_q;
  assign max_d = take ? rdat : max_q;
  assign mbin_d = take ? r_idx_q[BW-1:0] : mbin_q;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic sc;
    assign sc = st_q == ST_SCAN && scan_bank_q == 1'(b);
    assign ra[b] = sc ? scan_idx_q : s0_a_q[AW-1:0];
    assign we[b] = sc || (st_q == ST_INIT && init_cnt_q[AW] == 1'(b)) || (s2_v_q && s2_a_q[AW] == 1'(b));
    assign wa[b] = sc ? scan_idx_q : st_q == ST_INIT ? init_cnt_q[AW-1:0] : s2_a_q[AW-1:0];
    assign wd[b] = sc || st_q == ST_INIT ? '0 : s2_sum_q;
    hist_bank_ram #(.DEPTH(NC * NBIN), .AW(AW), .W(ACC_W)) u_ram (
      .clk(clk), .we(we[b]), .wa(wa[b]), .wd(wd[b]), .ra(ra[b]), .rd(rd[b])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st_q <= ST_INIT; init_cnt_q <= '0; cnt_w_q <= '0; cnt_h_q <= '0;
      s0_v_q <= 1'b0; s0_a_q <= '0; s0_m_q <= '0; s0_last_q <= 1'b0; s0_lf_q <= 1'b0; s0_cy_q <= '0;
      s1_v_q <= 1'b0; s1_a_q <= '0; s1_m_q <= '0; s1_last_q <= 1'b0; s1_lf_q <= 1'b0; s1_cy_q <= '0;
      s2_v_q <= 1'b0; s2_a_q <= '0; s2_sum_q <= '0; s2_last_q <= 1'b0; s2_lf_q <= 1'b0; s2_cy_q <= '0;
      pw_v_q <= 1'b0; pw_a_q <= '0; pw_sum_q <= '0;
      scan_bank_q <= 1'b0; scan_cy_q <= '0; scan_lf_q <= 1'b0; scan_idx_q <= '0;
      r_v_q <= 1'b0; r_idx_q <= '0; max_q <= '0; mbin_q <= '0;
      hv_q <= 1'b0; fd_q <= 1'b0; hx_q <= '0; hy_q <= '0; hb_q <= '0; hp_q <= '0; err_q <= '0;
    end else begin
      st_q <= st_q == ST_INIT ? (init_cnt_q == (AW+1)'(2 * NC * NBIN - 1) ? ST_IDLE : ST_INIT)
            : st_q == ST_SCAN ? (scan_idx_q == AW'(NC * NBIN - 1) ? ST_IDLE : ST_SCAN)
            : s2_v_q && s2_last_q ? ST_SCAN : ST_IDLE;
      init_cnt_q <= st_q == ST_INIT ? init_cnt_q + (AW+1)'(1) : '0;
      scan_idx_q <= st_q == ST_SCAN ? scan_idx_q + AW'(1) : '0;
      if (st_q == ST_IDLE && s2_v_q && s2_last_q) begin
        scan_bank_q <= s2_a_q[AW]; scan_cy_q <= s2_cy_q; scan_lf_q <= s2_lf_q;
      end
      if (acc) begin
        cnt_w_q <= cnt_w_q == CNT_DW'(WIDE - 1) ? '0 : cnt_w_q + CNT_DW'(1);
        if (cnt_w_q == CNT_DW'(WIDE - 1)) cnt_h_q <= cnt_h_q == CNT_DW'(HIGN - 1) ? '0 : cnt_h_q + CNT_DW'(1);
      end
      s0_v_q <= acc; s0_a_q <= {cnt_h_q[LC], cnt_w_q[LC +: CXW], the_in}; s0_m_q <= mag_in;
      s0_last_q <= row_end; s0_lf_q <= cnt_h_q == CNT_DW'(HIGN - 1); s0_cy_q <= 8'(cnt_h_q >> LC);
      s1_v_q <= s0_v_q; s1_a_q <= s0_a_q; s1_m_q <= s0_m_q; s1_last_q <= s0_last_q; s1_lf_q <= s0_lf_q; s1_cy_q <= s0_cy_q;
      s2_v_q <= s1_v_q; s2_a_q <= s1_a_q; s2_sum_q <= sum_d; s2_last_q <= s1_last_q; s2_lf_q <= s1_lf_q; s2_cy_q <= s1_cy_q;
      pw_v_q <= s2_v_q; pw_a_q <= s2_a_q; pw_sum_q <= s2_sum_q;
      r_v_q <= st_q == ST_SCAN; r_idx_q <= scan_idx_q;
      if (r_v_q) begin max_q <= max_d; mbin_q <= mbin_d; end
      hv_q <= r_v_q && last_bin;
      fd_q <= r_v_q && last_bin && scan_lf_q && r_idx_q[AW-1:BW] == CXW'(NC - 1);
      if (r_v_q && last_bin) begin
        hx_q <= 8'(r_idx_q[AW-1:BW]); hy_q <= scan_cy_q; hb_q <= mbin_d; hp_q <= max_d;
      end
      err_q <= err_q | {acc && st_q == ST_SCAN && cnt_h_q[LC] == scan_bank_q, valid_in && st_q == ST_INIT};
    end
  assign hist_valid = hv_q;
  assign hist_cell_x = hx_q;
  assign hist_cell_y = hy_q;
  assign hist_bin = hb_q;
  assign hist_peak = hp_q;
  assign frame_done = fd_q;
  assign init_busy = st_q == ST_INIT;
  assign err = err_q;
endmodule

// File: tb/tb_orient_hist_cell.sv
// tb_orient_hist_cell: scoreboard bench on 32x32 frames of 8x8 tiles, driving a 16-bit and
// an 8-bit accumulator instance with the same stream against hand-computed tile results.
module tb_orient_hist_cell;
  typedef struct packed {logic [7:0] cx; logic [7:0] cy; logic [3:0] bin; logic [15:0] peak; logic fd;} exp_t;
  logic clk = 0, rst = 0, valid_in = 0;
  logic [7:0] mag_in = 0;
  logic [3:0] the_in = 0;
  logic hv, fd, ib, hv8, fd8, ib8;
  logic [7:0] cx, cy, cx8, cy8, peak8;
  logic [3:0] bin, bin8;
  logic [15:0] peak;
  logic [1:0] err, err8;
  exp_t q[$], q8[$];
  exp_t g16, e16, g8, e8;
  int checks = 0, errors = 0, cyc = 0, last_hv = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  orient_hist_cell #(.WIDE(32), .HIGN(32), .DW(8), .CELL(8), .ACC_W(16), .CNT_DW(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mag_in(mag_in), .the_in(the_in),
    .hist_valid(hv), .hist_cell_x(cx), .hist_cell_y(cy), .hist_bin(bin), .hist_peak(peak),
    .frame_done(fd), .init_busy(ib), .err(err)
  );
  orient_hist_cell #(.WIDE(32), .HIGN(32), .DW(8), .CELL(8), .ACC_W(8), .CNT_DW(16)) dut8 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mag_in(mag_in), .the_in(the_in),
    .hist_valid(hv8), .hist_cell_x(cx8), .hist_cell_y(cy8), .hist_bin(bin8), .hist_peak(peak8),
    .frame_done(fd8), .init_busy(ib8), .err(err8)
  );
  always @(negedge clk) if (rst && hv) begin
    g16 = {cx, cy, bin, peak, fd};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL tile16 unexpected output cx=%0d cy=%0d bin=%0d peak=%0d fd=%0b", cx, cy, bin, peak, fd);
    end else begin
      e16 = q.pop_front();
      if (g16 !== e16) begin
        errors++;
        $display("FAIL tile16 got cx=%0d cy=%0d bin=%0d peak=%0d fd=%0b, required cx=%0d cy=%0d bin=%0d peak=%0d fd=%0b",
                 cx, cy, bin, peak, fd, e16.cx, e16.cy, e16.bin, e16.peak, e16.fd);
      end
    end
    if (cx != 0) begin
      checks++;
      if (cyc - last_hv != 16) begin
        errors++;
        $display("FAIL tile_spacing got %0d cycles, required 16", cyc - last_hv);
      end
    end
    last_hv = cyc;
  end
  always @(negedge clk) if (rst && hv8) begin
    g8 = {cx8, cy8, bin8, {8'd0, peak8}, fd8};
    checks++;
    if (q8.size() == 0) begin
      errors++;
      $display("FAIL tile8 unexpected output cx=%0d cy=%0d bin=%0d peak=%0d fd=%0b", cx8, cy8, bin8, peak8, fd8);
    end else begin
      e8 = q8.pop_front();
      if (g8 !== e8) begin
        errors++;
        $display("FAIL tile8 got cx=%0d cy=%0d bin=%0d peak=%0d fd=%0b, required cx=%0d cy=%0d bin=%0d peak=%0d fd=%0b",
                 cx8, cy8, bin8, peak8, fd8, e8.cx, e8.cy, e8.bin, e8.peak, e8.fd);
      end
    end
  end
  function automatic logic [11:0] pix(input int mode, input int x, input int y);
    int tx = x / 8, ty = y / 8, lx = x % 8, ly = y % 8;
    case (mode)
      1: return {8'd1, 4'd3};
      2: return tx == 0 && ty == 0 ? {8'd200, 4'd5} : {8'd0, 4'(x)};
      3: return tx == 1 && ty == 0 ? {8'd255, 4'd7} : {8'd0, 4'd2};
      4: return tx == 2 && ty == 1 && lx < 4 && (ly == 0 || ly == 7) ? {8'd25, ly == 0 ? 4'd9 : 4'd4} : {8'd0, 4'd12};
      6: return {8'd2, 4'd11};
      default: return {8'd0, 4'(y)};
    endcase
  endfunction
  function automatic exp_t expv(input int mode, input int tx, input int ty, input bit sat);
    exp_t r;
    r = '0;
    r.cx = 8'(tx);
    r.cy = 8'(ty);
    r.fd = tx == 3 && ty == 3;
    case (mode)
      1: begin r.bin = 3; r.peak = 64; end
      2: if (tx == 0 && ty == 0) begin r.bin = 5; r.peak = sat ? 16'd255 : 16'd12800; end
      3: if (tx == 1 && ty == 0) begin r.bin = 7; r.peak = sat ? 16'd255 : 16'd16320; end
      4: if (tx == 2 && ty == 1) begin r.bin = 4; r.peak = 100; end
      6: begin r.bin = 11; r.peak = 128; end
      default: ;
    endcase
    return r;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, req);
    end
  endtask
  task automatic count_init(input bit inject, output int n, output bit bad);
    n = 0;
    bad = 0;
    @(posedge clk);
    #1 rst = 1;
    while (n < 1000) begin
      @(negedge clk);
      if (!ib) break;
      n++;
      if (hv || fd || cx != 0 || cy != 0 || bin != 0 || peak != 0 || hv8 || peak8 != 0) bad = 1;
      if (!inject && (err != 0 || err8 != 0)) bad = 1;
      if (inject) begin valid_in = n == 3; mag_in = 8'd50; the_in = 4'd1; end
    end
  endtask
  task automatic send_frame(input int mode, input int lines, input bit gaps);
    logic [11:0] p;
    for (int ty = 0; ty < lines / 8; ty++)
      for (int tx = 0; tx < 4; tx++) begin
        q.push_back(expv(mode, tx, ty, 0));
        q8.push_back(expv(mode, tx, ty, 1));
      end
    for (int y = 0; y < lines; y++)
      for (int x = 0; x < 32; x++) begin
        if (gaps && x % 7 == 3) begin @(posedge clk); #1 valid_in = 0; end
        p = pix(mode, x, y);
        @(posedge clk);
        #1 valid_in = 1;
        mag_in = p[11:4];
        the_in = p[3:0];
      end
    @(posedge clk);
    #1 valid_in = 0;
  endtask
  task automatic drain();
    int i = 0;
    while ((q.size() != 0 || q8.size() != 0) && i < 2000) begin @(negedge clk); i++; end
    chk("drain_pending_tiles", 64'(q.size() + q8.size()), 0);
    q.delete();
    q8.delete();
    repeat (20) @(negedge clk);
  endtask
  initial begin
    int n;
    bit bad;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {hv, fd, ib, err, cx, cy, bin, peak}, {3'b001, 2'b00, 36'd0});
    count_init(0, n, bad);
    chk("init_cycles", n, 128);
    chk("init_outputs_quiet", bad, 0);
    @(posedge clk);
    #1 rst = 0;
    repeat (2) @(negedge clk);
    count_init(1, n, bad);
    chk("init_cycles_inject", n, 128);
    chk("init_outputs_quiet_inject", bad, 0);
    chk("err_sample_during_init", {err8, err}, 4'b0101);
    send_frame(1, 32, 1); drain();
    send_frame(2, 32, 0); drain();
    send_frame(3, 32, 0); drain();
    send_frame(4, 32, 0); drain();
    send_frame(5, 32, 0); drain();
    chk("err_sticky", {err8, err}, 4'b0101);
    send_frame(1, 12, 0); drain();
    @(posedge clk);
    #1 rst = 0;
    #1 chk("reset_midframe", {hv, fd, ib, err, hv8, err8}, 8'b0010_0000);
    repeat (3) @(negedge clk);
    count_init(0, n, bad);
    chk("init_cycles_restart", n, 128);
    chk("init_outputs_quiet_restart", bad, 0);
    send_frame(6, 32, 1); drain();
    chk("err_final", {err8, err}, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
